// File: rtl/ram_write_arbiter_if.sv
// rtl/ram_write_arbiter_if.sv - request/grant and RAM write-port bundle for ram_write_arbiter
interface ram_write_arbiter_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
);
   logic                  iReqA;
   logic [ADDR_WIDTH-1:0] iAddrA;
   logic [DATA_WIDTH-1:0] iDataA;
   logic                  oGrantA;
   logic                  iReqB;
   logic [ADDR_WIDTH-1:0] iAddrB;
   logic [DATA_WIDTH-1:0] iDataB;
   logic                  iLockB;
   logic                  oGrantB;
   logic                  oWriteEnable;
   logic [ADDR_WIDTH-1:0] oWriteAddress;
   logic [DATA_WIDTH-1:0] oWriteData;
   logic                  oLocked;
   logic [15:0]           oConflictCount;

   modport master (
      output iReqA, iAddrA, iDataA, iReqB, iAddrB, iDataB, iLockB,
      input  oGrantA, oGrantB, oWriteEnable, oWriteAddress, oWriteData, oLocked, oConflictCount
   );

   modport slave (
      input  iReqA, iAddrA, iDataA, iReqB, iAddrB, iDataB, iLockB,
      output oGrantA, oGrantB, oWriteEnable, oWriteAddress, oWriteData, oLocked, oConflictCount
   );
endinterface

// File: rtl/ram_write_arbiter.sv
// rtl/ram_write_arbiter.sv - round-robin write-port arbiter with B burst lock and conflict counter
module ram_write_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int MAX_LOCK   = 8
) (
   input  logic                Clock,
   input  logic                Reset,
   ram_write_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_LOCK_B, S_RELEASE} state_t;

   localparam logic [7:0] LOCK_LAST = 8'(MAX_LOCK - 1);

   state_t                r_state;
   state_t                w_next_state;
   logic [7:0]            r_lock_cnt;
   logic [7:0]            w_next_lock_cnt;
   logic                  r_last_b;
   logic                  w_next_last_b;
   logic                  r_locked;
   logic                  w_grant_a;
   logic                  w_grant_b;
   logic                  w_rr_grant_a;
   logic                  w_rr_grant_b;
   logic                  r_write_enable;
   logic [ADDR_WIDTH-1:0] r_write_addr;
   logic [DATA_WIDTH-1:0] r_write_data;
   logic [15:0]           r_conflict_count;

   // Round-robin pick: on a conflict the requester that did not win last time goes.
   assign w_rr_grant_a = bus.iReqA && (!bus.iReqB || r_last_b);
   assign w_rr_grant_b = bus.iReqB && (!bus.iReqA || !r_last_b);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state    <= S_IDLE;
         r_lock_cnt <= 8'd0;
         r_last_b   <= 1'b1;
         r_locked   <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_lock_cnt <= w_next_lock_cnt;
         r_last_b   <= w_next_last_b;
         r_locked   <= (w_next_state == S_LOCK_B);
      end
   end

   always_comb begin
      w_next_state    = r_state;
      w_next_lock_cnt = r_lock_cnt;
      w_next_last_b   = r_last_b;
      if (w_grant_a) begin
         w_next_last_b = 1'b0;
      end else if (w_grant_b) begin
         w_next_last_b = 1'b1;
      end
      case (r_state)
         S_IDLE: begin
            if (w_grant_b && bus.iLockB) begin
               w_next_lock_cnt = 8'd1;
               w_next_state    = (MAX_LOCK == 1) ? S_RELEASE : S_LOCK_B;
            end
         end
         S_LOCK_B: begin
            if (!bus.iLockB) begin
               w_next_state    = S_IDLE;
               w_next_lock_cnt = 8'd0;
            end else if (w_grant_b) begin
               if (r_lock_cnt >= LOCK_LAST) begin
                  w_next_state    = S_RELEASE;
                  w_next_lock_cnt = 8'd0;
               end else begin
                  w_next_lock_cnt = r_lock_cnt + 8'd1;
               end
            end
         end
         S_RELEASE: begin
            if (w_grant_a || w_grant_b) begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state    = S_IDLE;
            w_next_lock_cnt = 8'd0;
         end
      endcase
   end

   // Dropping iLockB while locked falls back to plain round-robin in that same cycle.
   always_comb begin
      w_grant_a = 1'b0;
      w_grant_b = 1'b0;
      if (!Reset) begin
         case (r_state)
            S_IDLE: begin
               w_grant_a = w_rr_grant_a;
               w_grant_b = w_rr_grant_b;
            end
            S_LOCK_B: begin
               if (!bus.iLockB) begin
                  w_grant_a = w_rr_grant_a;
                  w_grant_b = w_rr_grant_b;
               end else begin
                  w_grant_b = bus.iReqB;
               end
            end
            S_RELEASE: begin
               w_grant_a = bus.iReqA;
               w_grant_b = !bus.iReqA && bus.iReqB;
            end
            default: begin
               w_grant_a = 1'b0;
               w_grant_b = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_write_enable <= 1'b0;
         r_write_addr   <= '0;
         r_write_data   <= '0;
      end else begin
         r_write_enable <= w_grant_a || w_grant_b;
         if (w_grant_a) begin
            r_write_addr <= bus.iAddrA;
            r_write_data <= bus.iDataA;
         end else if (w_grant_b) begin
            r_write_addr <= bus.iAddrB;
            r_write_data <= bus.iDataB;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_conflict_count <= 16'd0;
      end else if (bus.iReqA && bus.iReqB && (r_conflict_count != 16'hFFFF)) begin
         r_conflict_count <= r_conflict_count + 16'd1;
      end
   end

   assign bus.oGrantA        = w_grant_a;
   assign bus.oGrantB        = w_grant_b;
   assign bus.oWriteEnable   = r_write_enable;
   assign bus.oWriteAddress  = r_write_addr;
   assign bus.oWriteData     = r_write_data;
   assign bus.oLocked        = r_locked;
   assign bus.oConflictCount = r_conflict_count;
endmodule

// File: tb/tb_ram_write_arbiter.sv
// tb/tb_ram_write_arbiter.sv - directed stimulus with write scoreboard for ram_write_arbiter
module tb_ram_write_arbiter;
   typedef struct packed {
      logic [7:0]  addr;
      logic [15:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   wr_t  exp_q[$];
   logic [7:0]  a_addr = 8'h30;
   logic [7:0]  b_addr = 8'h31;
   logic [15:0] a_data = 16'hA000;
   logic [15:0] b_data = 16'hB000;

   ram_write_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

   ram_write_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .MAX_LOCK(8)) dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // eg: 0 = no grant, 1 = grant A, 2 = grant B
   task automatic drive(input logic ra, input logic [7:0] aa, input logic [15:0] da,
                        input logic rb, input logic [7:0] ab, input logic [15:0] db,
                        input logic lk, input logic rs, input int eg, input string nm);
      @(negedge clk);
      rst        = rs;
      bus.iReqA  = ra;
      bus.iAddrA = aa;
      bus.iDataA = da;
      bus.iReqB  = rb;
      bus.iAddrB = ab;
      bus.iDataB = db;
      bus.iLockB = lk;
      #1;
      checks++;
      if (bus.oGrantA !== (eg == 1) || bus.oGrantB !== (eg == 2)) begin
         errors++;
         $display("FAIL grant %s: got A=%b B=%b, want A=%b B=%b", nm,
                  bus.oGrantA, bus.oGrantB, (eg == 1), (eg == 2));
      end
      if (eg == 1) exp_q.push_back('{addr: aa, data: da});
      else if (eg == 2) exp_q.push_back('{addr: ab, data: db});
   endtask

   task automatic both(input logic lk, input int eg, input string nm);
      drive(1'b1, a_addr, a_data, 1'b1, b_addr, b_data, lk, 1'b0, eg, nm);
      if (eg == 1) a_data = a_data + 16'd1;
      else if (eg == 2) b_data = b_data + 16'd1;
   endtask

   task automatic idle();
      drive(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 0, "idle");
   endtask

   task automatic do_reset(input string nm);
      drive(1'b1, a_addr, a_data, 1'b1, b_addr, b_data, 1'b1, 1'b1, 0, nm);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   // Every grant must surface on the write port exactly one cycle later, in grant order.
   initial begin
      wr_t e;
      forever begin
         @(posedge clk);
         #1;
         checks++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (bus.oWriteEnable !== 1'b1 || bus.oWriteAddress !== e.addr || bus.oWriteData !== e.data) begin
               errors++;
               $display("FAIL write: got we=%b addr=%h data=%h, want we=1 addr=%h data=%h",
                        bus.oWriteEnable, bus.oWriteAddress, bus.oWriteData, e.addr, e.data);
            end
         end else if (bus.oWriteEnable !== 1'b0) begin
            errors++;
            $display("FAIL write_idle: got we=%b, want we=0", bus.oWriteEnable);
         end
      end
   end

   initial begin
      bus.iReqA = 1'b0; bus.iAddrA = '0; bus.iDataA = '0;
      bus.iReqB = 1'b0; bus.iAddrB = '0; bus.iDataB = '0; bus.iLockB = 1'b0;

      do_reset("reset0");
      do_reset("reset1");
      chk("rst_we", 32'(bus.oWriteEnable), 32'd0);
      chk("rst_addr", 32'(bus.oWriteAddress), 32'd0);
      chk("rst_data", 32'(bus.oWriteData), 32'd0);
      chk("rst_locked", 32'(bus.oLocked), 32'd0);
      chk("rst_cc", 32'(bus.oConflictCount), 32'd0);

      drive(1'b1, 8'h05, 16'h1234, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1, "a_alone");
      idle();
      idle();

      drive(1'b1, 8'h40, 16'h1111, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1, "same_addr_a");
      drive(1'b0, 8'h00, 16'h0000, 1'b1, 8'h40, 16'h2222, 1'b0, 1'b0, 2, "same_addr_b");
      idle();

      do_reset("reset_rr");
      for (int i = 0; i < 6; i++) both(1'b0, (i % 2 == 0) ? 1 : 2, "alternate");
      idle();
      chk("cc_after_6", 32'(bus.oConflictCount), 32'd6);

      both(1'b1, 1, "lock_first_a");
      both(1'b1, 2, "lock_start_b");
      chk("locked_start", 32'(bus.oLocked), 32'd0);
      for (int i = 0; i < 7; i++) begin
         both(1'b1, 2, "lock_burst_b");
         chk("locked_burst", 32'(bus.oLocked), 32'd1);
      end
      both(1'b0, 1, "release_a");
      chk("locked_release", 32'(bus.oLocked), 32'd0);
      both(1'b0, 2, "resume_b");
      both(1'b0, 1, "resume_a");
      idle();
      chk("cc_after_lock", 32'(bus.oConflictCount), 32'd18);

      both(1'b1, 2, "lock3_1");
      both(1'b1, 2, "lock3_2");
      both(1'b1, 2, "lock3_3");
      chk("locked_3", 32'(bus.oLocked), 32'd1);
      both(1'b0, 1, "unlock_rr_a");
      idle();
      chk("unlocked_idle", 32'(bus.oLocked), 32'd0);
      chk("cc_after_lock3", 32'(bus.oConflictCount), 32'd22);

      both(1'b1, 2, "rstlock_b1");
      both(1'b1, 2, "rstlock_b2");
      do_reset("rstlock_reset");
      idle();
      chk("rstlock_locked", 32'(bus.oLocked), 32'd0);
      chk("rstlock_cc", 32'(bus.oConflictCount), 32'd0);
      both(1'b0, 1, "rstlock_first_a");

      do_reset("reset_sat");
      for (int i = 0; i < 65534; i++) both(1'b0, (i % 2 == 0) ? 1 : 2, "sat_rr");
      both(1'b0, 1, "sat_1");
      chk("cc_fffe", 32'(bus.oConflictCount), 32'hFFFE);
      both(1'b0, 2, "sat_2");
      chk("cc_ffff_a", 32'(bus.oConflictCount), 32'hFFFF);
      both(1'b0, 1, "sat_3");
      chk("cc_ffff_b", 32'(bus.oConflictCount), 32'hFFFF);
      idle();
      chk("cc_ffff_c", 32'(bus.oConflictCount), 32'hFFFF);
      idle();
      idle();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ram_write_arbiter.md
# ram_write_arbiter

Round-robin arbiter sharing the single write port of the dual-read-port data RAM between two requesters: requester A (the MiniAlu core's result writeback) and requester B (host/debug loader). Grants are combinational in the request cycle; the winning write is registered onto the RAM write port one cycle later. Requester B may lock the port for a bounded burst. A saturating conflict counter is provided for profiling.

## Interface
- ADDR_WIDTH, 8, RAM address width
- DATA_WIDTH, 16, RAM data width
- MAX_LOCK, 8, max consecutive B grants while locked (range 1..255)

- Clock  in  1  system clock, all logic on posedge
- Reset  in  1  synchronous, active-high; one clock, synchronous reset active-high
- iReqA  in  1  core write request; held with addr/data until oGrantA
- iAddrA  in  ADDR_WIDTH  core write address
- iDataA  in  DATA_WIDTH  core write data
- oGrantA  out  1  combinational grant to A
- iReqB  in  1  host write request; held with addr/data until oGrantB
- iAddrB  in  ADDR_WIDTH  host write address
- iDataB  in  DATA_WIDTH  host write data
- iLockB  in  1  host burst lock request, sampled with a granted iReqB
- oGrantB  out  1  combinational grant to B
- oWriteEnable  out  1  registered RAM write enable
- oWriteAddress  out  ADDR_WIDTH  registered RAM write address
- oWriteData  out  DATA_WIDTH  registered RAM write data
- oLocked  out  1  high while in LOCK_B
- oConflictCount  out  16  saturating count of cycles with iReqA and iReqB both high

## Operation
- States: IDLE (round-robin), LOCK_B (B exclusive), RELEASE (A priority for one arbitration).
- Register rLast: last granted requester; reset value B, so A wins the first conflict.
- IDLE: only one request -> grant it; both -> grant the requester that is not rLast. A grant updates rLast.
- IDLE -> LOCK_B when oGrantB and iLockB are both high in the same cycle. Lock counter loads 1, counting that grant.
- LOCK_B: grant B only; oGrantA=0. Each B grant increments the counter.
- LOCK_B -> IDLE when iLockB=0 (evaluated before that cycle's grant; in that cycle normal round-robin applies).
- LOCK_B -> RELEASE when the counter reaches MAX_LOCK after a B grant.
- RELEASE: if iReqA, grant A, set rLast=A and go to IDLE. If no iReqA, grant B if requested (no relock) and go to IDLE.
- Exactly one grant per cycle at most; oGrantA and oGrantB never both high.
- Writeback register: on a grant, capture the winner's addr/data and set oWriteEnable=1 for the next cycle. No grant -> oWriteEnable=0. Addr and data hold their last value when not written.
- Same address written by both requesters in consecutive cycles: RAM receives the writes in grant order, so the later write wins.
- oConflictCount increments each cycle with iReqA&iReqB, in any state, and saturates at 16'hFFFF.

## Timing
- Reset (synchronous): state=IDLE, rLast=B, lock counter=0, oWriteEnable=0, oWriteAddress=0, oWriteData=0, oLocked=0, oConflictCount=0. Grants are 0 during the Reset cycle.
- Reset during LOCK_B, or with a write pending in the output register: the next cycle shows IDLE and oWriteEnable=0; the pending write is dropped.
- Grant latency is 0 cycles, combinational from state, rLast and the requests.
- RAM write appears 1 cycle after the grant. Throughput is 1 write/cycle.
- Worst-case A wait: 1 cycle when unlocked; MAX_LOCK cycles during a lock (MAX_LOCK-1 if the lock began in the same cycle).
- oLocked is registered and equals (state==LOCK_B).

## Test plan
- Reset, then iReqA alone, addr 0x05, data 0x1234 -> oGrantA in the same cycle; next cycle oWriteEnable=1, addr 0x05, data 0x1234. Then oWriteEnable=0.
- Both requesting continuously for 6 cycles -> grants alternate A,B,A,B,A,B. oConflictCount=6.
- B locks with iLockB held and iReqA held, MAX_LOCK=8 -> 8 consecutive B grants, oLocked high; then RELEASE grants A once; then alternation resumes.
- B locks for 3 grants, then drops iLockB -> IDLE on the next cycle, and round-robin grants A.
- Reset asserted in the cycle after a B grant while locked -> oWriteEnable=0 the following cycle, oLocked=0, oConflictCount=0, and the next conflict goes to A.
- Force oConflictCount to 0xFFFE, then hold both requests for 3 cycles -> value reaches 0xFFFF and stays there.
